mrr_decoded_packetizer: RTL and testbench

Sits directly downstream of the header/decoder top level and consumes its decoded-word stream (o_decoded_tdata/tvalid/tlast). Buffers each decoded packet, stamps it with a header (magic, sequence, length, 64-bit capture time) and emits it as a framed AXI-stream toward the host.
Never back-pressures the decoder. Packets that cannot be buffered are dropped whole and counted.

---
 rtl/mrr_decoded_packetizer.sv | 213 +++++++++++++++++++++
 tb/tb_mrr_decoded_packetizer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mrr_decoded_packetizer.sv
// Buffers decoded packets, prepends a 3-word header (magic/seq/len, capture time) and emits framed AXI-stream.
// Optional trailer word (XOR of header+payload) when MRR_PKTZ_CHECKSUM_EN is defined.
module mrr_decoded_packetizer #(
  parameter int          DEPTH_LOG2      = 9,
  parameter int          DESC_DEPTH_LOG2 = 2,
  parameter logic [7:0]  MAGIC           = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           cur_time,
  input  logic [31:0]           s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count,
  output logic [DEPTH_LOG2:0]   fifo_level
);

`ifdef MRR_PKTZ_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DW = DESC_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [DW-1:0] D_ONE = DW'(1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_HDR0, R_HDR1, R_HDR2, R_PAY, R_TRL} r_state_t;

  logic [31:0] mem [0:(2**DEPTH_LOG2)-1];
  logic [75:0] desc_mem [0:(2**DESC_DEPTH_LOG2)-1];

  w_state_t      w_state_reg;
  r_state_t      r_state_reg;
  logic [PW-1:0] wr_spec_reg, wr_commit_reg, rd_ptr_reg;
  logic [DW-1:0] desc_wr_reg, desc_rd_reg;
  logic [11:0]   w_len_reg;
  logic [63:0]   ts_pending_reg;
  logic [11:0]   seq_reg, cur_len_reg, remaining_reg;
  logic [63:0]   cur_ts_reg;
  logic [31:0]   csum_reg, ram_q;

  logic          full, desc_full, desc_empty;
  logic          drop_now, wr_en, rd_advance;
  logic [11:0]   len_next;
  logic [63:0]   ts_now;
  logic [PW-1:0] rd_addr;
  logic [75:0]   desc_head;
  logic [31:0]   hdr0_word;

  assign s_tready   = rst;
  assign fifo_level = wr_spec_reg - rd_ptr_reg;

  // Full is judged against the registered read pointer, i.e. before any pop on this edge.
  assign full       = (wr_spec_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                      (wr_spec_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
  assign desc_full  = (desc_wr_reg[DW-1] != desc_rd_reg[DW-1]) &&
                      (desc_wr_reg[DW-2:0] == desc_rd_reg[DW-2:0]);
  assign desc_empty = (desc_wr_reg == desc_rd_reg);

  assign len_next = (w_state_reg == W_IDLE) ? 12'd1 : w_len_reg + 12'd1;
  assign ts_now   = (w_state_reg == W_IDLE) ? cur_time : ts_pending_reg;
  assign drop_now = s_tvalid && (w_state_reg != W_DISCARD) &&
                    (full || ((w_state_reg == W_FILL) && (w_len_reg == 12'hFFF)) ||
                     (s_tlast && desc_full));
  assign wr_en    = s_tvalid && (w_state_reg != W_DISCARD) && !drop_now;

  // The RAM output always tracks the next payload word; it is consumed when it moves into m_tdata.
  assign rd_advance = m_tready && ((r_state_reg == R_HDR2) ||
                      ((r_state_reg == R_PAY) && (remaining_reg != 12'd0)));
  assign rd_addr    = rd_advance ? rd_ptr_reg + P_ONE : rd_ptr_reg;
  assign desc_head  = desc_mem[desc_rd_reg[DW-2:0]];
  assign hdr0_word  = {MAGIC, seq_reg, desc_head[75:64]};

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_spec_reg[PW-2:0]] <= s_tdata;
    ram_q <= mem[rd_addr[PW-2:0]];
    if (wr_en && s_tlast)
      desc_mem[desc_wr_reg[DW-2:0]] <= {len_next, ts_now};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_reg    <= W_IDLE;
      wr_spec_reg    <= '0;
      wr_commit_reg  <= '0;
      desc_wr_reg    <= '0;
      w_len_reg      <= '0;
      ts_pending_reg <= '0;
      drop_count     <= '0;
    end else if (wr_en) begin
      wr_spec_reg <= wr_spec_reg + P_ONE;
      w_len_reg   <= len_next;
      if (w_state_reg == W_IDLE)
        ts_pending_reg <= cur_time;
      if (s_tlast) begin
        wr_commit_reg <= wr_spec_reg + P_ONE;
        desc_wr_reg   <= desc_wr_reg + D_ONE;
        w_state_reg   <= W_IDLE;
      end else begin
        w_state_reg <= W_FILL;
      end
    end else if (drop_now) begin
      wr_spec_reg <= wr_commit_reg;
      if (drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      w_state_reg <= s_tlast ? W_IDLE : W_DISCARD;
    end else if ((w_state_reg == W_DISCARD) && s_tvalid && s_tlast) begin
      w_state_reg <= W_IDLE;
    end
  end

  // The descriptor slot is held until the packet's final handshake, so it counts toward capacity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_reg   <= R_IDLE;
      rd_ptr_reg    <= '0;
      desc_rd_reg   <= '0;
      seq_reg       <= '0;
      pkt_count     <= '0;
      cur_len_reg   <= '0;
      cur_ts_reg    <= '0;
      remaining_reg <= '0;
      csum_reg      <= '0;
      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (!desc_empty) begin
            cur_len_reg <= desc_head[75:64];
            cur_ts_reg  <= desc_head[63:0];
            m_tdata     <= hdr0_word;
            csum_reg    <= hdr0_word;
            m_tvalid    <= 1'b1;
            m_tlast     <= 1'b0;
            r_state_reg <= R_HDR0;
          end
        end
        R_HDR0: begin
          if (m_tready) begin
            m_tdata     <= cur_ts_reg[63:32];
            csum_reg    <= csum_reg ^ cur_ts_reg[63:32];
            r_state_reg <= R_HDR1;
          end
        end
        R_HDR1: begin
          if (m_tready) begin
            m_tdata     <= cur_ts_reg[31:0];
            csum_reg    <= csum_reg ^ cur_ts_reg[31:0];
            r_state_reg <= R_HDR2;
          end
        end
        R_HDR2: begin
          if (m_tready) begin
            m_tdata       <= ram_q;
            csum_reg      <= csum_reg ^ ram_q;
            rd_ptr_reg    <= rd_ptr_reg + P_ONE;
            remaining_reg <= cur_len_reg - 12'd1;
            m_tlast       <= !CSUM_EN && (cur_len_reg == 12'd1);
            r_state_reg   <= R_PAY;
          end
        end
        R_PAY: begin
          if (m_tready) begin
            if (remaining_reg != 12'd0) begin
              m_tdata       <= ram_q;
              csum_reg      <= csum_reg ^ ram_q;
              rd_ptr_reg    <= rd_ptr_reg + P_ONE;
              remaining_reg <= remaining_reg - 12'd1;
              m_tlast       <= !CSUM_EN && (remaining_reg == 12'd1);
            end else if (CSUM_EN) begin
              m_tdata     <= csum_reg;
              m_tlast     <= 1'b1;
              r_state_reg <= R_TRL;
            end else begin
              m_tdata     <= '0;
              m_tvalid    <= 1'b0;
              m_tlast     <= 1'b0;
              seq_reg     <= seq_reg + 12'd1;
              pkt_count   <= pkt_count + 16'd1;
              desc_rd_reg <= desc_rd_reg + D_ONE;
              r_state_reg <= R_IDLE;
            end
          end
        end
        R_TRL: begin
          if (m_tready) begin
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            seq_reg     <= seq_reg + 12'd1;
            pkt_count   <= pkt_count + 16'd1;
            desc_rd_reg <= desc_rd_reg + D_ONE;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mrr_decoded_packetizer.sv
// Self-checking bench for mrr_decoded_packetizer: packet table plus reset / descriptor-full sequences,
// with a scoreboard queue of expected output beats.
module tb_mrr_decoded_packetizer;

`ifdef MRR_PKTZ_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] cur_time = '0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic [9:0]  fifo_level;

  mrr_decoded_packetizer dut (
    .clk(clk), .rst(rst), .cur_time(cur_time),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .pkt_count(pkt_count), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 3;
  int exp_pkts = 0;
  int exp_drops = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] step;
    logic [63:0] t;
    int          rmode;
    int          kind;    // 0 emitted, 1 dropped
    bit          drain;
    logic [31:0] hdr0;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ready pattern: 0 always high, 1 toggle, 2 random, 3 held low.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pop, stall stability, intra-packet bubbles.
  logic        have_stall = 1'b0;
  logic        in_pkt = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;
  logic [32:0] exp_beat;
  always @(negedge clk) begin
    if (!rst) begin
      have_stall = 1'b0;
      in_pkt = 1'b0;
    end else begin
      if (have_stall)
        chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, stall_last, stall_data});
      if (in_pkt && !m_tvalid)
        chk("bubble", 64'(m_tvalid), 64'd1);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_tlast, m_tdata}, 64'h1_FFFF_FFFF);
        end else begin
          exp_beat = exp_q.pop_front();
          chk("beat", {m_tlast, m_tdata}, exp_beat);
        end
        in_pkt = !m_tlast;
        have_stall = 1'b0;
      end else if (m_tvalid) begin
        have_stall = 1'b1;
        stall_data = m_tdata;
        stall_last = m_tlast;
      end else begin
        have_stall = 1'b0;
      end
    end
  end

  // kind 0: expect emission with header hdr0; 1: expect drop; 2: no expectation.
  task automatic send_pkt(input int n, input logic [31:0] base, input logic [31:0] step,
                          input logic [63:0] t, input int kind, input logic [31:0] hdr0);
    logic [31:0] w;
    logic [31:0] x;
    if (kind == 0) begin
      x = hdr0 ^ t[63:32] ^ t[31:0];
      exp_q.push_back({1'b0, hdr0});
      exp_q.push_back({1'b0, t[63:32]});
      exp_q.push_back({1'b0, t[31:0]});
      for (int i = 0; i < n; i++) begin
        w = base + step * 32'(i);
        x = x ^ w;
        exp_q.push_back({(i == n - 1) && !CSUM, w});
      end
      if (CSUM) exp_q.push_back({1'b1, x});
      exp_pkts++;
    end else if (kind == 1) begin
      exp_drops++;
    end
    cur_time = t;
    for (int i = 0; i < n; i++) begin
      s_tdata  = base + step * 32'(i);
      s_tvalid = 1'b1;
      s_tlast  = (i == n - 1);
      tick(1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick(3);
  endtask

  initial begin
    vecs[0] = '{3,   32'h11,       32'h11,   64'h0000_0001_0000_0010, 0, 0, 1'b1, 32'hA500_0003};
    vecs[1] = '{4,   32'h100,      32'h1,    64'h1234_5678_9ABC_DEF0, 1, 0, 1'b0, 32'hA500_1004};
    vecs[2] = '{2,   32'h200,      32'h1,    64'h0000_0000_0000_0042, 1, 0, 1'b1, 32'hA500_2002};
    vecs[3] = '{513, 32'h1000,     32'h1,    64'h0,                   3, 1, 1'b1, 32'h0};
    vecs[4] = '{2,   32'h300,      32'h1,    64'h0000_0002_0000_0003, 0, 0, 1'b1, 32'hA500_3002};
    vecs[5] = '{7,   32'hDEAD_0000, 32'h1357, 64'hFFFF_0000_5555_AAAA, 2, 0, 1'b1, 32'hA500_4007};

    // Reset state
    tick(3);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    rst = 1'b1;
    tick(1);
    chk("idle_s_tready", 64'(s_tready), 64'd1);
    chk("idle_outputs", {m_tvalid, m_tlast, m_tdata}, 64'd0);
    chk("idle_counts", {pkt_count, drop_count}, 64'd0);
    chk("idle_level", 64'(fifo_level), 64'd0);

    for (int v = 0; v < 6; v++) begin
      ready_mode = vecs[v].rmode;
      send_pkt(vecs[v].n, vecs[v].base, vecs[v].step, vecs[v].t, vecs[v].kind, vecs[v].hdr0);
      if (vecs[v].drain) begin
        drain();
        chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
        chk("drop_count", 64'(drop_count), 64'(exp_drops));
        chk("fifo_level", 64'(fifo_level), 64'd0);
      end
    end

    // Reset mid-output and mid-packet
    ready_mode = 3;
    send_pkt(2, 32'h77, 32'h1, 64'h9, 2, 32'h0);
    tick(2);
    chk("mid_output_valid", 64'(m_tvalid), 64'd1);
    s_tdata = 32'h88; s_tvalid = 1'b1; s_tlast = 1'b0;
    tick(2);
    s_tvalid = 1'b0;
    rst = 1'b0;
    tick(1);
    chk("mrst_outputs", {m_tvalid, m_tlast, m_tdata}, 64'd0);
    chk("mrst_counts", {pkt_count, drop_count}, 64'd0);
    chk("mrst_level", 64'(fifo_level), 64'd0);
    chk("mrst_s_tready", 64'(s_tready), 64'd0);
    rst = 1'b1;
    exp_q.delete();
    exp_pkts = 0;
    exp_drops = 0;
    ready_mode = 0;
    tick(1);
    send_pkt(1, 32'hCAFE, 32'h0, 64'h5_0000_0006, 0, 32'hA500_0001);
    drain();
    chk("mrst_pkt_count", 64'(pkt_count), 64'd1);

    // Descriptor FIFO full: 4 committed packets held, 5th dropped
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    exp_pkts = 0;
    exp_drops = 0;
    ready_mode = 3;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      send_pkt(1, 32'h500 + 32'(i), 32'h0, 64'(i), 0, {8'hA5, 12'(i), 12'd1});
      tick(1);
    end
    send_pkt(1, 32'h600, 32'h0, 64'h0, 1, 32'h0);
    tick(2);
    chk("descfull_drop", 64'(drop_count), 64'd1);
    chk("descfull_held", 64'(pkt_count), 64'd0);
    ready_mode = 0;
    drain();
    chk("descfull_pkts", 64'(pkt_count), 64'd4);
    chk("descfull_level", 64'(fifo_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
